// File: rtl/hp_axi_pkg.sv
// Shared AXI3 constants and arbiter state encoding for the HP write port arbiter.
package hp_axi_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] SIZE_WORD     = 3'b010;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } ArbState;

    // Snapshot of the granted requester's descriptor, held for the whole burst.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [5:0]  id;
    } aw_req_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/hp_write_arbiter_if.sv
// AXI3 write-only channel bundle (AW, W, B) between the arbiter and the HP slave port.
interface hp_write_arbiter_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [5:0]  awid;
    logic [1:0]  awburst;
    logic [2:0]  awsize;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [5:0]  wid;

    logic        bvalid;
    logic        bready;
    logic [5:0]  bid;
    logic [1:0]  bresp;

    modport master (
        output awvalid, awaddr, awlen, awid, awburst, awsize, awlock, awcache, awprot, awqos,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wid,
        input  wready,
        input  bvalid, bid, bresp,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awid, awburst, awsize, awlock, awcache, awprot, awqos,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wid,
        output wready,
        output bvalid, bid, bresp,
        input  bready
    );

endinterface

// File: rtl/hp_write_arbiter_rr_arbiter.sv
// Round-robin priority picker: one-hot grant to the first requester at or after pointer.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] pointer,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit so pointer+i can be folded back into 0..N-1.
            sum = {1'b0, pointer} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N))
                sum = sum - (PTR_W+1)'(N);
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hp_write_arbiter.sv
// Shares one AXI3 HP write port between NUM_REQ burst requesters, routing B back by ID.
// Optional: define HP_WRITE_ARB_ERR_CNT_EN to add a saturating err_count output.
module hp_write_arbiter
    import hp_axi_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ID_BASE         = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][31:0]  req_addr,
    input  logic [NUM_REQ-1:0][3:0]   req_len,
    input  logic [NUM_REQ-1:0]        wd_valid,
    output logic [NUM_REQ-1:0]        wd_ready,
    input  logic [NUM_REQ-1:0][31:0]  wd_data,
    output logic [NUM_REQ-1:0]        done_valid,
    output logic [1:0]                done_resp,
    hp_write_arbiter_if.master        axi
`ifdef HP_WRITE_ARB_ERR_CNT_EN
    ,
    output logic [15:0]               err_count
`endif
);

    localparam int         PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);
    localparam logic [6:0] ID_LO = 7'(ID_BASE);
    localparam logic [6:0] ID_HI = 7'(ID_BASE + NUM_REQ);

    ArbState          state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    aw_req_t          aw_q;
    logic             awvalid_q;
    logic [3:0]       beats;
    logic [3:0]       outst;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               aw_hs, w_hs, b_hs, in_data, bid_ok;
    logic [5:0]         bid_off;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req     (req_valid),
        .pointer (ptr),
        .grant   (pick_oh)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_oh[i]) pick_idx = PTR_W'(i);
    end

    assign in_data = (state == DATA);
    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign b_hs    = axi.bvalid && axi.bready;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = aw_q.addr;
    assign axi.awlen   = aw_q.len;
    assign axi.awid    = aw_q.id;
    assign axi.awburst = BURST_INCR;
    assign axi.awsize  = SIZE_WORD;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = CACHE_DEFAULT;
    assign axi.awprot  = 3'b000;
    assign axi.awqos   = 4'h0;

    // W is a pure mux of the owning requester; everything is gated off outside DATA.
    assign axi.wvalid = in_data && wd_valid[gnt_idx];
    assign axi.wdata  = in_data ? wd_data[gnt_idx] : 32'h0;
    assign axi.wid    = in_data ? aw_q.id : 6'h0;
    assign axi.wlast  = in_data && (beats == 4'h0);
    assign axi.wstrb  = 4'hF;

    assign axi.bready = (outst != 4'h0);
    assign bid_ok     = ({1'b0, axi.bid} >= ID_LO) && ({1'b0, axi.bid} < ID_HI);
    assign bid_off    = axi.bid - 6'(ID_BASE);

    always_comb begin
        req_ready  = '0;
        wd_ready   = '0;
        done_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                req_ready[i] = (state == ADDR) && axi.awready;
                wd_ready[i]  = in_data && axi.wready;
            end
            if (b_hs && bid_ok && (bid_off == 6'(i)))
                done_valid[i] = 1'b1;
        end
    end

    assign done_resp = (|done_valid) ? axi.bresp : RESP_OKAY;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            aw_q      <= '0;
            awvalid_q <= 1'b0;
            beats     <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if ((outst < MAX_O) && (|req_valid)) begin
                        gnt_idx   <= pick_idx;
                        aw_q.addr <= req_addr[pick_idx];
                        aw_q.len  <= req_len[pick_idx];
                        aw_q.id   <= 6'(ID_BASE) + 6'(pick_idx);
                        awvalid_q <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    beats <= aw_q.len;
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (beats == 4'h0) begin
                            ptr   <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                            state <= IDLE;
                        end else begin
                            beats <= beats - 4'h1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Concurrent AW and B handshakes cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            outst <= 4'h0;
        else if (aw_hs && !b_hs)
            outst <= outst + 4'h1;
        else if (b_hs && !aw_hs)
            outst <= outst - 4'h1;
    end

`ifdef HP_WRITE_ARB_ERR_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err_count <= 16'h0;
        else if (b_hs && resp_is_err(axi.bresp) && (err_count != 16'hFFFF))
            err_count <= err_count + 16'h1;
    end
`endif

endmodule

// File: tb/tb_hp_write_arbiter.sv
// Directed bench for hp_write_arbiter: NUM_REQ=2, ID_BASE=8, MAX_OUTSTANDING=4.
module tb_hp_write_arbiter;

    localparam int IDB = 8;

    logic              clock;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_addr;
    logic [1:0][3:0]   req_len;
    logic [1:0]        wd_valid;
    logic [1:0]        wd_ready;
    logic [1:0][31:0]  wd_data;
    logic [1:0]        done_valid;
    logic [1:0]        done_resp;
`ifdef HP_WRITE_ARB_ERR_CNT_EN
    logic [15:0]       err_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    hp_write_arbiter_if axi ();

    hp_write_arbiter #(.NUM_REQ(2), .ID_BASE(IDB), .MAX_OUTSTANDING(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wd_valid   (wd_valid),
        .wd_ready   (wd_ready),
        .wd_data    (wd_data),
        .done_valid (done_valid),
        .done_resp  (done_resp),
        .axi        (axi)
`ifdef HP_WRITE_ARB_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        int g;
        logic hs_prev;

        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0;
        wd_valid = '0; wd_data = '0;
        axi.awready = 1'b1; axi.wready = 1'b1;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_awvalid", 32'(axi.awvalid), 0);
        chk("rst_wvalid", 32'(axi.wvalid), 0);
        chk("rst_bready", 32'(axi.bready), 0);
        chk("rst_done", 32'(done_valid), 0);
        tick(); tick();
        reset = 1'b1;

        // Single len-3 burst from requester 0.
        req_valid = 2'b01; req_addr[0] = 32'h1000; req_len[0] = 4'd3;
        wd_valid = 2'b01; wd_data[0] = 32'hA;
        tick();
        chk("t1_awvalid", 32'(axi.awvalid), 1);
        chk("t1_awaddr", axi.awaddr, 32'h1000);
        chk("t1_awlen", 32'(axi.awlen), 3);
        chk("t1_awid", 32'(axi.awid), IDB);
        chk("t1_awburst", 32'(axi.awburst), 1);
        chk("t1_awsize", 32'(axi.awsize), 2);
        chk("t1_awcache", 32'(axi.awcache), 3);
        chk("t1_req_ready", 32'(req_ready), 1);
        chk("t1_no_w_in_addr", 32'(wd_ready), 0);
        tick();
        req_valid = 2'b00;
        chk("t1_bready", 32'(axi.bready), 1);
        for (int b = 0; b < 4; b++) begin
            chk("t1_wvalid", 32'(axi.wvalid), 1);
            chk("t1_wdata", axi.wdata, 32'hA + 32'(b));
            chk("t1_wlast", 32'(axi.wlast), 32'(b == 3));
            chk("t1_wid", 32'(axi.wid), IDB);
            chk("t1_wd_ready", 32'(wd_ready), 1);
            wd_data[0] = 32'hA + 32'(b) + 1;
            tick();
        end
        wd_valid = 2'b00;
        chk("t1_w_idle", 32'(axi.wvalid), 0);
        axi.bvalid = 1'b1; axi.bid = 6'(IDB); axi.bresp = 2'b00;
        #1;
        chk("t1_done", 32'(done_valid), 1);
        chk("t1_done_resp", 32'(done_resp), 0);
        tick();
        axi.bvalid = 1'b0;
        #1;
        chk("t1_bready_low", 32'(axi.bready), 0);

        // Round robin with len 0; pointer now sits at 1.
        req_valid = 2'b11; req_len[0] = 4'd0; req_len[1] = 4'd0;
        req_addr[0] = 32'h2000; req_addr[1] = 32'h3000;
        wd_valid = 2'b11; wd_data[0] = 32'h100; wd_data[1] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            g = 1 - (i % 2);
            tick();
            chk("rr_awvalid", 32'(axi.awvalid), 1);
            chk("rr_awid", 32'(axi.awid), 32'(IDB + g));
            chk("rr_awaddr", axi.awaddr, (g == 1) ? 32'h3000 : 32'h2000);
            chk("rr_req_ready", 32'(req_ready), 32'(1 << g));
            tick();
            chk("rr_wid", 32'(axi.wid), 32'(IDB + g));
            chk("rr_wdata", axi.wdata, (g == 1) ? 32'h200 : 32'h100);
            chk("rr_wlast", 32'(axi.wlast), 1);
            chk("rr_wd_ready", 32'(wd_ready), 32'(1 << g));
            tick();
            chk("rr_idle", 32'(axi.awvalid), 0);
        end

        // Four bursts outstanding: IDLE must hold.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lim_hold", 32'(axi.awvalid), 0);
        end
        axi.bvalid = 1'b1; axi.bid = 6'(IDB + 1); axi.bresp = 2'b00;
        #1;
        chk("lim_done1", 32'(done_valid), 2);
        tick();
        axi.bvalid = 1'b0;
        chk("lim_hold_b", 32'(axi.awvalid), 0);
        tick();
        chk("lim_one_more", 32'(axi.awvalid), 1);
        chk("lim_awid", 32'(axi.awid), IDB + 1);
        tick();
        chk("lim_wid", 32'(axi.wid), IDB + 1);
        tick();
        tick();
        chk("lim_full_again", 32'(axi.awvalid), 0);
        tick();
        chk("lim_full_again2", 32'(axi.awvalid), 0);

        // Same-cycle AW and B, with an out-of-range bid.
        axi.bvalid = 1'b1; axi.bid = 6'(IDB); axi.bresp = 2'b00;
        #1;
        chk("sc_done0", 32'(done_valid), 1);
        tick();
        axi.bvalid = 1'b0;
        chk("sc_hold", 32'(axi.awvalid), 0);
        tick();
        chk("sc_awid", 32'(axi.awid), IDB);
        axi.bvalid = 1'b1; axi.bid = 6'h3F; axi.bresp = 2'b10;
        #1;
        chk("sc_oor_done", 32'(done_valid), 0);
        chk("sc_oor_resp", 32'(done_resp), 0);
        chk("sc_req_ready", 32'(req_ready), 1);
        tick();
        axi.bvalid = 1'b0;
        chk("sc_wid", 32'(axi.wid), IDB);
        tick();
        tick();
        chk("sc_slot_left", 32'(axi.awvalid), 1);
        chk("sc_slot_awid", 32'(axi.awid), IDB + 1);
        tick();
        tick();
        tick();
        chk("sc_full", 32'(axi.awvalid), 0);
        tick();
        chk("sc_full2", 32'(axi.awvalid), 0);
`ifdef HP_WRITE_ARB_ERR_CNT_EN
        chk("err_cnt1", 32'(err_count), 1);
`endif

        // SLVERR completion, then reset in the middle of a DATA phase.
        req_valid = 2'b01; req_len[0] = 4'd3; wd_valid = 2'b01; wd_data[0] = 32'h77;
        axi.bvalid = 1'b1; axi.bid = 6'(IDB + 1); axi.bresp = 2'b10;
        #1;
        chk("err_done", 32'(done_valid), 2);
        chk("err_resp", 32'(done_resp), 2);
        tick();
        axi.bvalid = 1'b0;
`ifdef HP_WRITE_ARB_ERR_CNT_EN
        chk("err_cnt2", 32'(err_count), 2);
`endif
        tick();
        tick();
        chk("mr_in_data", 32'(axi.wvalid), 1);
        reset = 1'b0;
        #1;
        chk("mr_awvalid", 32'(axi.awvalid), 0);
        chk("mr_wvalid", 32'(axi.wvalid), 0);
        chk("mr_wlast", 32'(axi.wlast), 0);
        chk("mr_wdata", axi.wdata, 0);
        chk("mr_wd_ready", 32'(wd_ready), 0);
        chk("mr_bready", 32'(axi.bready), 0);
        chk("mr_done", 32'(done_valid), 0);
`ifdef HP_WRITE_ARB_ERR_CNT_EN
        chk("mr_err_cnt", 32'(err_count), 0);
`endif
        tick();
        reset = 1'b1;

        // First grant after reset goes to requester 0; then a backpressured burst.
        req_valid = 2'b11; req_addr[0] = 32'h4000; req_len[0] = 4'd3; req_len[1] = 4'd0;
        wd_valid = 2'b00; wd_data[0] = 32'h50;
        tick();
        chk("pr_awid", 32'(axi.awid), IDB);
        chk("pr_awaddr", axi.awaddr, 32'h4000);
        chk("pr_awlen", 32'(axi.awlen), 3);
        tick();
        req_valid = 2'b00;
        k = 0;
        hs_prev = 1'b0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (hs_prev) wd_data[0] = 32'h50 + 32'(k);
            axi.wready = (c % 2 == 1);
            wd_valid[0] = !(c == 2 || c == 3);
            #1;
            chk("bp_wvalid", 32'(axi.wvalid), 32'(wd_valid[0]));
            hs_prev = axi.wvalid && axi.wready;
            if (hs_prev) begin
                chk("bp_wdata", axi.wdata, 32'h50 + 32'(k));
                chk("bp_wlast", 32'(axi.wlast), 32'(k == 3));
                k++;
            end
            tick();
        end
        chk("bp_beats", 32'(k), 4);
        axi.wready = 1'b1; wd_valid = 2'b01;
        #1;
        chk("bp_no_extra", 32'(wd_ready), 0);
        chk("bp_wvalid_off", 32'(axi.wvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
